// File: rtl/branch_resolve_stage_pkg.sv
// Shared constants and decode helpers for the execute-stage branch resolver.
package branch_resolve_stage_pkg;

    localparam int unsigned WORD_SIZE_DEFAULT  = 32;
    localparam logic [31:0] PC_INITIAL_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        CT_NONE,
        CT_BRANCH,
        CT_JAL,
        CT_JALR
    } ctrl_kind_e;

    // Classify an opcode as a control transfer or not.
    function automatic ctrl_kind_e decode_ctrl(input logic [6:0] opcode);
        ctrl_kind_e kind;
        kind = CT_NONE;
        case (opcode)
            OP_BRANCH: kind = CT_BRANCH;
            OP_JAL:    kind = CT_JAL;
            OP_JALR:   kind = CT_JALR;
            default:   kind = CT_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/branch_resolve_stage_compare.sv
// Conditional-branch comparator; purely combinational so early-branch logic can reuse it.
module branch_compare
    import branch_resolve_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       funct3,
    output logic             taken
);

    // Evaluate the branch condition selected by funct3; undefined codes never take.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) <  $signed(b));
            F3_BGE:  taken = ($signed(a) >= $signed(b));
            F3_BLTU: taken = (a <  b);
            F3_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_stage.sv
// Execute-stage pipeline register with branch/JAL/JALR resolution, fetch redirect and statistics.
module branch_resolve_stage
    import branch_resolve_stage_pkg::*;
#(
    parameter int unsigned           WORD_SIZE  = WORD_SIZE_DEFAULT,
    parameter logic [WORD_SIZE-1:0]  PC_INITIAL = WORD_SIZE'(PC_INITIAL_DEFAULT),
    parameter int unsigned           CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] InstrD,
    input  logic [WORD_SIZE-1:0] PCD,
    input  logic [WORD_SIZE-1:0] PCPlus4D,
    input  logic [WORD_SIZE-1:0] RD1D,
    input  logic [WORD_SIZE-1:0] RD2D,
    input  logic [WORD_SIZE-1:0] ImmExtD,
    input  logic                 FlushE,
    output logic                 PCSrcE,
    output logic [WORD_SIZE-1:0] PCTargetE,
    output logic                 FlushD,
    output logic [WORD_SIZE-1:0] PCPlus4E,
    output logic                 ValidE,
    output logic [CNT_WIDTH-1:0] BranchCnt,
    output logic [CNT_WIDTH-1:0] TakenCnt
);

    logic [WORD_SIZE-1:0] InstrE_q, PCE_q, PCPlus4E_q, RD1E_q, RD2E_q, ImmExtE_q;
    logic [CNT_WIDTH-1:0] BranchCnt_q, BranchCnt_d, TakenCnt_q, TakenCnt_d;

    ctrl_kind_e           kind;
    logic                 cond_taken;
    logic                 is_ctrl;
    logic [WORD_SIZE-1:0] pc_rel_sum;
    logic [WORD_SIZE-1:0] reg_rel_sum;

    branch_compare #(.WIDTH(WORD_SIZE)) u_cmp (
        .a      (RD1E_q),
        .b      (RD2E_q),
        .funct3 (InstrE_q[14:12]),
        .taken  (cond_taken)
    );

    // Decode the E instruction and form the redirect request and target.
    always_comb begin
        kind        = decode_ctrl(InstrE_q[6:0]);
        ValidE      = (InstrE_q != '0);
        pc_rel_sum  = PCE_q + ImmExtE_q;
        reg_rel_sum = RD1E_q + ImmExtE_q;
        is_ctrl     = 1'b0;
        PCSrcE      = 1'b0;
        PCTargetE   = '0;
        if (ValidE) begin
            case (kind)
                CT_BRANCH: begin
                    is_ctrl   = 1'b1;
                    PCSrcE    = cond_taken;
                    PCTargetE = pc_rel_sum;
                end
                CT_JAL: begin
                    is_ctrl   = 1'b1;
                    PCSrcE    = 1'b1;
                    PCTargetE = pc_rel_sum;
                end
                CT_JALR: begin
                    is_ctrl   = 1'b1;
                    PCSrcE    = 1'b1;
                    PCTargetE = reg_rel_sum & {{(WORD_SIZE-1){1'b1}}, 1'b0};
                end
                default: begin
                    is_ctrl   = 1'b0;
                    PCSrcE    = 1'b0;
                    PCTargetE = '0;
                end
            endcase
        end
        FlushD      = PCSrcE;
        BranchCnt_d = BranchCnt_q + (is_ctrl ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
        TakenCnt_d  = TakenCnt_q  + (PCSrcE  ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
    end

    // E pipeline register: a redirect or hazard flush inserts a single bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrE_q   <= '0;
            PCE_q      <= PC_INITIAL;
            PCPlus4E_q <= '0;
            RD1E_q     <= '0;
            RD2E_q     <= '0;
            ImmExtE_q  <= '0;
        end else if (FlushE || PCSrcE) begin
            InstrE_q   <= '0;
            PCE_q      <= '0;
            PCPlus4E_q <= '0;
            RD1E_q     <= '0;
            RD2E_q     <= '0;
            ImmExtE_q  <= '0;
        end else begin
            InstrE_q   <= InstrD;
            PCE_q      <= PCD;
            PCPlus4E_q <= PCPlus4D;
            RD1E_q     <= RD1D;
            RD2E_q     <= RD2D;
            ImmExtE_q  <= ImmExtD;
        end
    end

    // Statistics counters; wrap silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BranchCnt_q <= '0;
            TakenCnt_q  <= '0;
        end else begin
            BranchCnt_q <= BranchCnt_d;
            TakenCnt_q  <= TakenCnt_d;
        end
    end

    assign PCPlus4E  = PCPlus4E_q;
    assign BranchCnt = BranchCnt_q;
    assign TakenCnt  = TakenCnt_q;

endmodule
